// File: rtl/imm_encoder_if.sv
// imm_encoder_if -- handshake bundle between a record producer/consumer and
// the immediate encoder.
//
// Signals:
//   in_valid / in_ready   input record handshake
//   in_class              2-bit format select (0=D, 1=CB, 2=B, 3=I)
//   in_instr              32-bit base instruction
//   in_imm                N-bit two's complement immediate
//   out_valid / out_ready output record handshake
//   out_instr             instruction with immediate field inserted
//   out_ovf               immediate did not fit the selected field
//   err_count             saturating count of delivered overflow records
//
// Modports:
//   master -- producer/consumer side (drives inputs and out_ready)
//   slave  -- encoder side
interface imm_encoder_if #(
  parameter int N = 64
);
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_class;
  logic [31:0]  in_instr;
  logic [N-1:0] in_imm;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_instr;
  logic         out_ovf;
  logic [15:0]  err_count;

  modport master (
    output in_valid, in_class, in_instr, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_ovf, err_count
  );

  modport slave (
    input  in_valid, in_class, in_instr, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_ovf, err_count
  );
endinterface

// File: rtl/imm_encoder.sv
// imm_encoder -- two-stage pipelined immediate-field encoder.
//
// Takes a base instruction and an immediate, inserts the low W bits of the
// immediate into the field selected by in_class and flags values that the
// field cannot represent. Stage S1 registers the raw record; the encoding is
// computed combinationally from S1 and registered into S2, which drives the
// outputs. Both stages use valid/ready flow control with a combinational
// ready path so that a full pipeline still moves one record per cycle.
//
// Formats:   class 0 (D)  9-bit signed   bits [20:12]
//            class 1 (CB) 19-bit signed  bits [23:5]
//            class 2 (B)  26-bit signed  bits [25:0]
//            class 3 (I)  12-bit unsigned bits [21:10]
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    imm_encoder_if.slave handshake bundle (see interface header)
//
// N must be at least 32 so the widest field slice exists in in_imm.
module imm_encoder #(
  parameter int N = 64
) (
  input  logic          clk,
  input  logic          reset,
  imm_encoder_if.slave  bus
);

  // Stage 1: raw captured record
  logic         s1_valid_q;
  logic [1:0]   s1_class_q;
  logic [31:0]  s1_instr_q;
  logic [N-1:0] s1_imm_q;

  // Stage 2: encoded record driving the outputs
  logic         s2_valid_q;
  logic [31:0]  s2_instr_q;
  logic         s2_ovf_q;
  logic [15:0]  err_count_q;

  logic         s1_load;
  logic         s2_load;
  logic         out_fire;

  // Encoder datapath between S1 and S2
  logic [4:0]   field_w;
  logic [4:0]   field_lsb;
  logic         signed_fmt;
  logic [31:0]  low_mask;
  logic [31:0]  field_mask;
  logic [N-1:0] hi_bits;
  logic [31:0]  enc_instr_d;
  logic         enc_ovf_d;

  // Flow control: a stage may load when it is empty or its content leaves
  // this cycle, so the ready chain reaches back combinationally from
  // out_ready and a full pipeline still accepts one record per cycle.
  assign s2_load  = !s2_valid_q || bus.out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign out_fire = s2_valid_q && bus.out_ready;

  always_comb begin
    field_w    = 5'd12;
    field_lsb  = 5'd10;
    signed_fmt = 1'b0;
    case (s1_class_q)
      2'd0: begin
        field_w    = 5'd9;
        field_lsb  = 5'd12;
        signed_fmt = 1'b1;
      end
      2'd1: begin
        field_w    = 5'd19;
        field_lsb  = 5'd5;
        signed_fmt = 1'b1;
      end
      2'd2: begin
        field_w    = 5'd26;
        field_lsb  = 5'd0;
        signed_fmt = 1'b1;
      end
      default: begin
        field_w    = 5'd12;
        field_lsb  = 5'd10;
        signed_fmt = 1'b0;
      end
    endcase
  end

  always_comb begin
    low_mask    = (32'd1 << field_w) - 32'd1;
    field_mask  = low_mask << field_lsb;
    enc_instr_d = (s1_instr_q & ~field_mask)
                | ((s1_imm_q[31:0] & low_mask) << field_lsb);
    if (signed_fmt) begin
      // Arithmetic shift leaves only copies of bit W-1 and above; the value
      // fits iff those bits are all zero or all one.
      hi_bits   = $unsigned($signed(s1_imm_q) >>> (field_w - 5'd1));
      enc_ovf_d = !((hi_bits == '0) || (hi_bits == '1));
    end else begin
      hi_bits   = s1_imm_q >> field_w;
      enc_ovf_d = (hi_bits != '0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_class_q <= '0;
      s1_instr_q <= '0;
      s1_imm_q   <= '0;
    end else if (s1_load) begin
      s1_valid_q <= bus.in_valid;
      // Payload only moves with a real record so idle inputs cause no change.
      if (bus.in_valid) begin
        s1_class_q <= bus.in_class;
        s1_instr_q <= bus.in_instr;
        s1_imm_q   <= bus.in_imm;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid_q <= 1'b0;
      s2_instr_q <= '0;
      s2_ovf_q   <= 1'b0;
    end else if (s2_load) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_instr_q <= enc_instr_d;
        s2_ovf_q   <= enc_ovf_d;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count_q <= '0;
    end else if (out_fire && s2_ovf_q && (err_count_q != 16'hFFFF)) begin
      err_count_q <= err_count_q + 16'd1;
    end
  end

  assign bus.in_ready  = s1_load;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_instr = s2_instr_q;
  assign bus.out_ovf   = s2_ovf_q;
  assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder -- self-checking bench for imm_encoder.
// A queue-based scoreboard holds the expected encoding of every accepted
// record, computed from the format rules with plain arithmetic; one compare
// process checks outputs on every cycle, directed vectors pin the model.
module tb_imm_encoder;
  localparam int N = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  imm_encoder_if #(.N(N)) bus ();

  imm_encoder #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0]  cls;
    logic [31:0] instr;
    logic [63:0] imm;
  } rec_t;

  typedef struct {
    logic [31:0] instr;
    logic        ovf;
    logic [63:0] imm;
    logic [1:0]  cls;
  } exp_t;

  int checks = 0;
  int failures = 0;
  int out_count = 0;
  int accepted = 0;
  int err_model = 0;
  rec_t pend[$];
  exp_t q[$];
  exp_t e;
  logic        hold_valid = 1'b0;
  logic [31:0] hold_instr;
  logic        hold_ovf;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int fwidth(input logic [1:0] c);
    case (c)
      2'd0: return 9;
      2'd1: return 19;
      2'd2: return 26;
      default: return 12;
    endcase
  endfunction

  function automatic int flsb(input logic [1:0] c);
    case (c)
      2'd0: return 12;
      2'd1: return 5;
      2'd2: return 0;
      default: return 10;
    endcase
  endfunction

  // Representable range: signed [-2^(W-1), 2^(W-1)-1], unsigned [0, 4095].
  function automatic logic model_ovf(input logic [1:0] c, input logic [63:0] imm);
    longint s;
    longint lim;
    s = longint'(imm);
    if (c == 2'd3) return (imm >= 64'd4096);
    lim = longint'(1) <<< (fwidth(c) - 1);
    return (s < -lim) || (s > lim - 1);
  endfunction

  function automatic logic [31:0] model_instr(input logic [1:0] c, input logic [31:0] instr,
                                              input logic [63:0] imm);
    logic [31:0] r;
    r = instr;
    for (int b = 0; b < fwidth(c); b++) r[flsb(c) + b] = imm[b];
    return r;
  endfunction

  // Reference sign-extension unit: field back to a 64-bit immediate.
  function automatic logic [63:0] sext_unit(input logic [1:0] c, input logic [31:0] instr);
    logic [63:0] v;
    int w;
    int l;
    w = fwidth(c);
    l = flsb(c);
    v = '0;
    for (int b = 0; b < w; b++) v[b] = instr[l + b];
    if (c != 2'd3 && instr[l + w - 1])
      for (int b = w; b < 64; b++) v[b] = 1'b1;
    return v;
  endfunction

  function automatic logic [63:0] rand_imm(input logic [1:0] c);
    longint lim;
    longint base;
    lim = (c == 2'd3) ? (longint'(1) <<< 12) : (longint'(1) <<< (fwidth(c) - 1));
    case ($urandom_range(3))
      0: return {$urandom, $urandom};
      1: base = lim;
      2: base = (c == 2'd3) ? longint'(0) : -lim;
      default: base = longint'($urandom_range(2000)) - 1000;
    endcase
    return 64'(base + longint'($urandom_range(3)) - 2);
  endfunction

  function automatic rec_t rand_rec();
    rec_t r;
    r.cls   = 2'($urandom_range(3));
    r.instr = $urandom;
    r.imm   = rand_imm(r.cls);
    return r;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!reset) begin
      q.delete();
      err_model = 0;
      hold_valid = 1'b0;
    end else begin
      chk("err_count", 64'(bus.err_count), 64'(err_model));
      if (hold_valid) begin
        chk("hold_valid", 64'(bus.out_valid), 64'(1));
        chk("hold_instr", 64'(bus.out_instr), 64'(hold_instr));
        chk("hold_ovf", 64'(bus.out_ovf), 64'(hold_ovf));
      end
      if (bus.out_valid && bus.out_ready) begin
        out_count++;
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=%h required=none", bus.out_instr);
        end else begin
          e = q.pop_front();
          chk("out_instr", 64'(bus.out_instr), 64'(e.instr));
          chk("out_ovf", 64'(bus.out_ovf), 64'(e.ovf));
          if (!e.ovf) chk("roundtrip", sext_unit(e.cls, bus.out_instr), e.imm);
          $display("TX %0d cls=%0d imm=%h -> instr=%h ovf=%0d", out_count, e.cls, e.imm,
                   bus.out_instr, bus.out_ovf);
          if (e.ovf && err_model < 65535) err_model++;
        end
      end
      hold_valid = bus.out_valid && !bus.out_ready;
      hold_instr = bus.out_instr;
      hold_ovf   = bus.out_ovf;
      if (bus.in_valid && bus.in_ready)
        q.push_back('{model_instr(bus.in_class, bus.in_instr, bus.in_imm),
                      model_ovf(bus.in_class, bus.in_imm), bus.in_imm, bus.in_class});
    end
  end

  // ---------------- driver ----------------
  task automatic drive_cycle(input bit rdy, input bit offer);
    @(posedge clk);
    #1;
    bus.out_ready = rdy;
    if (offer && pend.size() > 0) begin
      bus.in_valid = 1'b1;
      bus.in_class = pend[0].cls;
      bus.in_instr = pend[0].instr;
      bus.in_imm   = pend[0].imm;
    end else begin
      bus.in_valid = 1'b0;
      bus.in_class = 2'($urandom_range(3));
      bus.in_instr = $urandom;
      bus.in_imm   = {$urandom, $urandom};
    end
    @(negedge clk);
    if (bus.in_valid && bus.in_ready) begin
      void'(pend.pop_front());
      accepted++;
    end
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (pend.size() > 0 || q.size() > 0); i++) drive_cycle(1'b1, 1'b1);
    chk("drain_empty", 64'(pend.size() + q.size()), 64'(0));
  endtask

  // Record accepted at edge k: S1 at k, S2 (out_valid) after edge k+1.
  task automatic directed(input string name, input logic [1:0] c, input logic [31:0] ins,
                          input logic [63:0] imm, input logic [31:0] ei, input logic eo);
    pend.push_back('{c, ins, imm});
    drive_cycle(1'b1, 1'b1);
    chk({name, "_accept"}, 64'(pend.size()), 64'(0));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk({name, "_not_yet"}, 64'(bus.out_valid), 64'(0));
    @(posedge clk);
    #1;
    chk({name, "_valid"}, 64'(bus.out_valid), 64'(1));
    chk({name, "_instr"}, 64'(bus.out_instr), 64'(ei));
    chk({name, "_ovf"}, 64'(bus.out_ovf), 64'(eo));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int o0;
    int o1;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_class = '0;
    bus.in_instr = '0;
    bus.in_imm = '0;
    bus.out_ready = 1'b0;
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_out_instr", 64'(bus.out_instr), 64'(0));
    chk("rst_out_ovf", 64'(bus.out_ovf), 64'(0));
    chk("rst_err_count", 64'(bus.err_count), 64'(0));
    #21 reset = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
    #1;

    // Model pins
    chk("model_d", 64'(model_instr(2'd0, 32'hF8400000, 64'h8)), 64'(32'hF8408000));
    chk("model_ovf_b", 64'(model_ovf(2'd2, 64'h0200_0000)), 64'(1));
    chk("model_sext_cb", sext_unit(2'd1, 32'hB4FFFFC0), 64'hFFFF_FFFF_FFFF_FFFE);

    directed("d_pos", 2'd0, 32'hF8400000, 64'h8, 32'hF8408000, 1'b0);
    directed("d_neg1", 2'd0, 32'hF8400000, 64'hFFFF_FFFF_FFFF_FFFF, 32'hF85FF000, 1'b0);
    directed("d_ovf", 2'd0, 32'hF8400000, 64'h100, 32'hF8500000, 1'b1);
    chk("err_after_d_ovf", 64'(bus.err_count), 64'(1));
    directed("cb_m2", 2'd1, 32'hB4000000, 64'hFFFF_FFFF_FFFF_FFFE, 32'hB4FFFFC0, 1'b0);
    directed("i_ovf", 2'd3, 32'h91000000, 64'h1000, 32'h91000000, 1'b1);
    directed("i_max", 2'd3, 32'h91000000, 64'hFFF, 32'h913FFC00, 1'b0);
    directed("b_min", 2'd2, 32'h14000000, 64'hFFFF_FFFF_FE00_0000, 32'h16000000, 1'b0);
    chk("err_after_i_ovf", 64'(bus.err_count), 64'(2));
    drain();

    // Stall: 5 cycles of out_ready=0 while offering 4 records
    for (int i = 0; i < 4; i++) pend.push_back(rand_rec());
    accepted = 0;
    repeat (5) drive_cycle(1'b0, 1'b1);
    chk("stall_accepted", 64'(accepted), 64'(2));
    chk("stall_in_ready", 64'(bus.in_ready), 64'(0));
    o0 = out_count;
    for (int i = 0; i < 20 && (pend.size() > 0 || q.size() > 0); i++) drive_cycle(1'b1, 1'b1);
    chk("stall_delivered", 64'(out_count - o0), 64'(4));

    // Sustained throughput
    for (int i = 0; i < 20; i++) pend.push_back(rand_rec());
    accepted = 0;
    repeat (5) drive_cycle(1'b1, 1'b1);
    o0 = out_count;
    repeat (15) drive_cycle(1'b1, 1'b1);
    o1 = out_count;
    chk("sustained_accept", 64'(accepted), 64'(20));
    chk("sustained_out", 64'(o1 - o0), 64'(15));
    drain();

    // Random traffic
    for (int i = 0; i < 1000; i++) pend.push_back(rand_rec());
    for (int i = 0; i < 20000 && (pend.size() > 0 || q.size() > 0); i++)
      drive_cycle(1'($urandom_range(99) < 70), 1'($urandom_range(99) < 75));
    chk("random_done", 64'(pend.size() + q.size()), 64'(0));

    // Mid-stream reset with both stages full
    pend.push_back('{2'd3, 32'h0, 64'h1_0000});
    pend.push_back('{2'd0, 32'h0, 64'h400});
    pend.push_back('{2'd1, 32'h0, 64'h0});
    repeat (3) drive_cycle(1'b0, 1'b1);
    chk("pre_reset_full", 64'(bus.out_valid), 64'(1));
    reset = 1'b0;
    bus.in_valid = 1'b0;
    pend.delete();
    #1;
    chk("async_out_valid", 64'(bus.out_valid), 64'(0));
    chk("async_err_count", 64'(bus.err_count), 64'(0));
    chk("async_out_instr", 64'(bus.out_instr), 64'(0));
    chk("async_out_ovf", 64'(bus.out_ovf), 64'(0));
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    o0 = out_count;
    repeat (4) drive_cycle(1'b1, 1'b1);
    chk("no_stale_out", 64'(out_count - o0), 64'(0));
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'(1));
    directed("post_rst", 2'd0, 32'hF8400000, 64'h100, 32'hF8500000, 1'b1);
    chk("post_rst_err", 64'(bus.err_count), 64'(1));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
